// File: rtl/sim_ctrl_mmio.sv
// Simulation-control MMIO responder: a char-output port feeding a console byte
// FIFO and a halt port that drains the FIFO before raising a sticky io_halt.

module sim_ctrl_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic [CW-1:0] count
);
  logic [DEPTH-1:0][7:0] mem;
  logic [AW-1:0]         wptr, rptr;
  logic                  pop_ok;

  // Pointers wrap for free because DEPTH is a power of two.
  assign pop_ok = pop & (count != '0);
  assign dout   = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= din;
        wptr      <= wptr + AW'(1);
      end
      if (pop_ok)
        rptr <= rptr + AW'(1);
      case ({push, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module sim_ctrl_mmio #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] CHAR_ADDR = 32'h0003_0000,
  parameter logic [31:0] HALT_ADDR = 32'h0003_0004
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ready,
  input  logic        io_req_valid,
  output logic        io_req_ready,
  input  logic        io_req_write,
  input  logic [31:0] io_req_addr,
  input  logic [31:0] io_req_wdata,
  output logic        io_resp_valid,
  output logic [31:0] io_resp_rdata,
  output logic        io_out_valid,
  output logic [7:0]  io_out_bits,
  input  logic        io_out_ready,
  output logic        io_halt,
  output logic [7:0]  io_exitCode
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t        state, state_d;
  logic [CW-1:0] count;
  logic          full, accept, is_char, is_halt;
  logic          push, pop, halt_st, char_ld;
  logic [7:0]    exit_code;
  logic          unused_wdata;

  assign unused_wdata = ^io_req_wdata[31:8];

  // full comes from the registered count, so io_out_ready never reaches io_req_ready.
  assign full         = (count == CW'(DEPTH));
  assign io_req_ready = ~reset & ready & (state == RUN) & ~full;
  assign accept       = io_req_valid & io_req_ready;
  assign is_char      = (io_req_addr == CHAR_ADDR);
  assign is_halt      = (io_req_addr == HALT_ADDR);
  assign push         = accept & io_req_write & is_char;
  assign halt_st      = accept & io_req_write & is_halt;
  assign char_ld      = accept & ~io_req_write & is_char;
  assign pop          = io_out_valid & io_out_ready;

  sim_ctrl_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (push),
    .din   (io_req_wdata[7:0]),
    .pop   (pop),
    .dout  (io_out_bits),
    .count (count)
  );

  assign io_out_valid = (count != '0);
  assign io_halt      = (state == HALTED);
  assign io_exitCode  = exit_code;

  always_comb begin
    state_d = state;
    case (state)
      RUN:     if (halt_st) state_d = DRAIN;
      DRAIN:   if (count == '0) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= RUN;
      io_resp_valid <= 1'b0;
      io_resp_rdata <= '0;
      exit_code     <= '0;
    end else begin
      state         <= state_d;
      io_resp_valid <= accept;
      // Occupancy is sampled in the accept cycle, before this edge's push/pop.
      io_resp_rdata <= char_ld ? {{(32-CW){1'b0}}, count} : 32'h0;
      if (halt_st)
        exit_code <= io_req_wdata[7:0];
    end
  end
endmodule

// File: tb/tb_sim_ctrl_mmio.sv
// Directed table-driven bench for sim_ctrl_mmio plus drain/halt timing sequences.

module tb_sim_ctrl_mmio;
  localparam logic [31:0] C = 32'h0003_0000;
  localparam logic [31:0] H = 32'h0003_0004;

  logic        clock = 1'b0;
  logic        reset, ready, io_req_valid, io_req_ready, io_req_write;
  logic [31:0] io_req_addr, io_req_wdata, io_resp_rdata;
  logic        io_resp_valid, io_out_valid, io_out_ready, io_halt;
  logic [7:0]  io_out_bits, io_exitCode;

  always #5 clock = ~clock;

  sim_ctrl_mmio dut (
    .clock(clock), .reset(reset), .ready(ready),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
    .io_req_write(io_req_write), .io_req_addr(io_req_addr),
    .io_req_wdata(io_req_wdata), .io_resp_valid(io_resp_valid),
    .io_resp_rdata(io_resp_rdata), .io_out_valid(io_out_valid),
    .io_out_bits(io_out_bits), .io_out_ready(io_out_ready),
    .io_halt(io_halt), .io_exitCode(io_exitCode)
  );

  typedef struct {
    logic        rst, rdy, vld, wr;
    logic [31:0] addr, wd;
    logic        ordy;
    logic        e_rr, e_rv;
    logic [31:0] e_rd;
    logic        e_ov;
    logic [7:0]  e_ob;
    logic        e_h;
    logic [7:0]  e_ex;
  } vec_t;

  vec_t tv[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic rst, rdy, vld, wr, input logic [31:0] addr, wd,
                     input logic ordy, e_rr, e_rv, input logic [31:0] e_rd,
                     input logic e_ov, input logic [7:0] e_ob,
                     input logic e_h, input logic [7:0] e_ex);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.vld = vld; v.wr = wr; v.addr = addr; v.wd = wd;
    v.ordy = ordy; v.e_rr = e_rr; v.e_rv = e_rv; v.e_rd = e_rd; v.e_ov = e_ov;
    v.e_ob = e_ob; v.e_h = e_h; v.e_ex = e_ex;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, rdy, vld, wr, input logic [31:0] addr, wd,
                       input logic ordy);
    reset = rst; ready = rdy; io_req_valid = vld; io_req_write = wr;
    io_req_addr = addr; io_req_wdata = wd; io_out_ready = ordy;
  endtask

  task automatic step;
    @(posedge clock); #1;
  endtask

  initial begin
    logic [7:0] got[$];
    int last, hc;

    // reset/idle and two-char path
    add(1,1,0,0,0,0,1, 0,0,0,0,8'h00,0,8'h00);
    add(0,1,0,0,0,0,1, 1,0,0,0,8'h00,0,8'h00);
    add(0,1,1,1,C,32'h48,1, 1,0,0,0,8'h00,0,8'h00);
    add(0,1,1,1,C,32'h69,1, 1,1,0,1,8'h48,0,8'h00);
    add(0,1,0,0,0,0,1, 1,1,0,1,8'h69,0,8'h00);
    add(0,1,0,0,0,0,1, 1,0,0,0,8'h00,0,8'h00);
    // fill to full with consumer stalled; load blocked until a pop
    for (int i = 0; i < 8; i++)
      add(0,1,1,1,C,i,0, 1,(i>0),0,(i>0),8'h00,0,8'h00);
    add(0,1,1,0,C,0,0, 0,1,0,1,8'h00,0,8'h00);
    add(0,1,1,0,C,0,0, 0,0,0,1,8'h00,0,8'h00);
    add(0,1,1,0,C,0,1, 0,0,0,1,8'h00,0,8'h00);
    add(0,1,1,0,C,0,0, 1,0,0,1,8'h01,0,8'h00);
    for (int i = 0; i < 4; i++)
      add(0,1,1,1,C,8+i,1, 1,1,(i==0)?7:0,1,8'(1+i),0,8'h00);
    add(0,1,0,0,0,0,1, 1,1,0,1,8'h05,0,8'h00);
    for (int j = 6; j < 12; j++)
      add(0,1,0,0,0,0,1, 1,0,0,1,8'(j),0,8'h00);
    add(0,1,0,0,0,0,1, 1,0,0,0,8'h00,0,8'h00);
    // ready gating: no accept, console still drains
    add(0,1,1,1,C,32'h31,0, 1,0,0,0,8'h00,0,8'h00);
    add(0,1,1,1,C,32'h32,0, 1,1,0,1,8'h31,0,8'h00);
    add(0,0,1,1,C,32'h33,1, 0,1,0,1,8'h31,0,8'h00);
    add(0,0,1,1,C,32'h33,1, 0,0,0,1,8'h32,0,8'h00);
    add(0,0,1,1,C,32'h33,1, 0,0,0,0,8'h00,0,8'h00);
    add(0,1,1,1,C,32'h33,1, 1,0,0,0,8'h00,0,8'h00);
    add(0,1,0,0,0,0,1, 1,1,0,1,8'h33,0,8'h00);
    add(0,1,0,0,0,0,1, 1,0,0,0,8'h00,0,8'h00);
    // halt with drain
    add(0,1,1,1,C,32'h61,0, 1,0,0,0,8'h00,0,8'h00);
    add(0,1,1,1,C,32'h62,0, 1,1,0,1,8'h61,0,8'h00);
    add(0,1,1,1,C,32'h63,0, 1,1,0,1,8'h61,0,8'h00);
    add(0,1,1,0,C,0,0, 1,1,0,1,8'h61,0,8'h00);
    add(0,1,1,1,H,32'h2A,0, 1,1,3,1,8'h61,0,8'h00);
    add(0,1,1,1,C,32'h77,0, 0,1,0,1,8'h61,0,8'h2A);
    add(0,1,1,1,C,32'h77,0, 0,0,0,1,8'h61,0,8'h2A);
    add(0,1,1,1,C,32'h77,1, 0,0,0,1,8'h61,0,8'h2A);
    add(0,1,1,1,C,32'h77,1, 0,0,0,1,8'h62,0,8'h2A);
    add(0,1,1,1,C,32'h77,1, 0,0,0,1,8'h63,0,8'h2A);
    add(0,1,0,0,0,0,1, 0,0,0,0,8'h00,0,8'h2A);
    add(0,1,0,0,0,0,1, 0,0,0,0,8'h00,1,8'h2A);
    add(0,1,0,0,0,0,1, 0,0,0,0,8'h00,1,8'h2A);
    // reset out of HALTED, then reset in DRAIN with 2 bytes queued
    add(1,1,0,0,0,0,0, 0,0,0,0,8'h00,1,8'h2A);
    add(0,1,1,1,C,32'h41,0, 1,0,0,0,8'h00,0,8'h00);
    add(0,1,1,1,C,32'h42,0, 1,1,0,1,8'h41,0,8'h00);
    add(0,1,1,1,H,32'h05,0, 1,1,0,1,8'h41,0,8'h00);
    add(1,1,0,0,0,0,0, 0,1,0,1,8'h41,0,8'h05);
    add(0,1,0,0,0,0,0, 1,0,0,0,8'h00,0,8'h00);
    add(0,1,1,1,C,32'h43,0, 1,0,0,0,8'h00,0,8'h00);
    add(0,1,1,0,H,0,1, 1,1,0,1,8'h43,0,8'h00);
    add(0,1,1,1,32'h1234,32'h55,1, 1,1,0,0,8'h00,0,8'h00);
    add(0,1,1,0,C,0,1, 1,1,0,0,8'h00,0,8'h00);
    add(0,1,0,0,0,0,1, 1,1,0,0,8'h00,0,8'h00);
    add(0,1,0,0,0,0,1, 1,0,0,0,8'h00,0,8'h00);

    drive(1,0,0,0,0,0,0);
    repeat (2) step();
    chk("reset rdata", io_resp_rdata, 32'h0);
    chk("reset out_bits", {24'h0, io_out_bits}, 32'h0);

    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].rdy, tv[i].vld, tv[i].wr, tv[i].addr, tv[i].wd, tv[i].ordy);
      #2;
      chk($sformatf("v%0d req_ready", i), io_req_ready, tv[i].e_rr);
      chk($sformatf("v%0d resp_valid", i), io_resp_valid, tv[i].e_rv);
      if (tv[i].e_rv) chk($sformatf("v%0d rdata", i), io_resp_rdata, tv[i].e_rd);
      chk($sformatf("v%0d out_valid", i), io_out_valid, tv[i].e_ov);
      if (tv[i].e_ov) chk($sformatf("v%0d out_bits", i), io_out_bits, tv[i].e_ob);
      chk($sformatf("v%0d halt", i), io_halt, tv[i].e_h);
      chk($sformatf("v%0d exit", i), io_exitCode, tv[i].e_ex);
      step();
    end

    // drain sequence: halt must follow the last pop by exactly one edge
    drive(1,1,0,0,0,0,0);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(0,1,1,1,C,32'hA0+k,0);
      step();
    end
    drive(0,1,1,1,H,32'h11,0);
    step();
    drive(0,1,0,0,0,0,1);
    last = -1;
    hc = -1;
    for (int c = 0; c < 20 && hc < 0; c++) begin
      #2;
      if (io_halt) hc = c;
      else if (io_out_valid) begin
        got.push_back(io_out_bits);
        last = c;
      end
      step();
    end
    chk("drain halt seen", (hc >= 0), 1);
    chk("drain byte count", got.size(), 3);
    for (int k = 0; k < got.size() && k < 3; k++)
      chk($sformatf("drain byte%0d", k), got[k], 32'hA0 + k);
    chk("drain halt lag", hc, last + 2);
    chk("drain exit", io_exitCode, 32'h11);

    // empty-FIFO halt: DRAIN one cycle after accept, io_halt the cycle after
    drive(1,1,0,0,0,0,1);
    step();
    drive(0,1,1,1,H,32'h7F,1);
    #2;
    chk("eh accept", io_req_ready, 1);
    step();
    drive(0,1,1,1,C,32'h01,1);
    #2;
    chk("eh drain req_ready", io_req_ready, 0);
    chk("eh drain halt", io_halt, 0);
    chk("eh resp", io_resp_valid, 1);
    step();
    #2;
    chk("eh halt", io_halt, 1);
    chk("eh exit", io_exitCode, 32'h7F);
    chk("eh no resp", io_resp_valid, 0);
    chk("eh no push", io_out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sim_ctrl_mmio.md
# sim_ctrl_mmio

Memory-mapped simulation-control responder on the core side of the top-level `io_halt` interface. It accepts CPU store and load requests to two MMIO words: a character-output port feeding a console byte FIFO, and a halt port carrying an exit code. After a halt store it drains all queued characters to the console consumer, then asserts `io_halt`. The top-level bench ends the run on the first clock edge where `io_halt` is high.

## Interface
Parameters:
- `DEPTH`, 8: console FIFO entries; power of two, at least 2.
- `CHAR_ADDR`, 32'h0003_0000: character-output word address.
- `HALT_ADDR`, 32'h0003_0004: halt word address.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ready`  in  1  global run enable. Low blocks request acceptance only.
- `io_req_valid`  in  1  CPU request present.
- `io_req_ready`  out  1  request accepted this cycle when high together with valid.
- `io_req_write`  in  1  1 = store, 0 = load.
- `io_req_addr`  in  32  word address.
- `io_req_wdata`  in  32  store data.
- `io_resp_valid`  out  1  one-cycle response pulse.
- `io_resp_rdata`  out  32  load data; 0 for stores.
- `io_out_valid`  out  1  console byte available.
- `io_out_bits`  out  8  console byte (FIFO head).
- `io_out_ready`  in  1  consumer takes the byte.
- `io_halt`  out  1  sticky halt indication.
- `io_exitCode`  out  8  latched exit code, valid while `io_halt` is high.

## Operation
- FSM states:
  - RUN: default.
  - DRAIN: halt received, flushing the FIFO.
  - HALTED: terminal until reset.
- `io_req_ready` = `ready` & (state == RUN) & !full.
  - Full-FIFO backpressure applies to all requests, including loads and halt stores.
  - `io_req_ready` is 0 in DRAIN and HALTED.
- An accepted request is acked with `io_resp_valid` = 1 on the next cycle.
  - `io_resp_valid` pulses once per accepted request.
  - Back-to-back accepts produce back-to-back pulses.
- Store to CHAR_ADDR: push `io_req_wdata[7:0]` into the FIFO.
- Store to HALT_ADDR: latch `io_req_wdata[7:0]` into the exit-code register and go to DRAIN.
- Load from CHAR_ADDR: return the FIFO occupancy, zero-extended, sampled in the accept cycle.
- Load from HALT_ADDR, or any access to another address: load returns 0; store is ignored. Both are still acked.
- FIFO is a circular buffer: read and write pointers wrap modulo DEPTH, plus a count of 0..DEPTH.
  - `io_out_valid` = (count != 0).
  - `io_out_bits` = mem[rptr].
  - Pop on `io_out_valid & io_out_ready`, in every state. The console side is not gated by `ready`.
  - Push and pop in the same cycle: both pointers advance and count is unchanged.
  - Once `io_out_valid` is high, it and `io_out_bits` stay stable until the pop.
- DRAIN → HALTED when count == 0 at a clock edge. `io_halt` is then 1 until reset.
- Reset mid-operation (any state) discards FIFO contents and the exit code and returns to RUN.

## Timing
- Reset values:
  - `io_req_ready` = 0 while `reset` is high.
  - `io_resp_valid` = 0, `io_resp_rdata` = 0.
  - `io_out_valid` = 0, `io_out_bits` = 0.
  - `io_halt` = 0, `io_exitCode` = 0.
  - State RUN, count 0, pointers 0.
- Char store accepted at cycle N into an empty FIFO: `io_out_valid` = 1 at N+1.
- Halt store accepted at N with the FIFO empty:
  - State is DRAIN at N+1.
  - `io_halt` = 1 at N+2.
- With k bytes queued and the consumer always ready, `io_halt` rises exactly 1 cycle after the last pop edge.
- `io_exitCode` is driven from the register in every state and is defined only while `io_halt` = 1.
- No combinational path from `io_out_ready` to `io_req_ready`: full is computed from the registered count.

## Test plan
- Reset and idle: hold `reset` 3 cycles, then `ready` = 1 with no requests → all outputs 0, `io_req_ready` = 1 from the first post-reset cycle.
- Char path: store 0x48 then 0x69 to 0x30000 on consecutive cycles, consumer always ready:
  - 2 resp pulses.
  - Bytes 0x48, 0x69 appear on `io_out_bits` in order.
  - Each byte first appears with `io_out_valid` 1 cycle after its accept.
- Backpressure and wrap: `io_out_ready` = 0, store 8 bytes 0x00..0x07:
  - `io_req_ready` drops after the 8th accept.
  - Load of 0x30000 is blocked until a pop.
  - Release the consumer, push 4 more (0x08..0x0B) → output sequence 0x00..0x0B with no loss.
- Halt with drain: queue 3 bytes with the consumer stalled, store 0x2A to 0x30004:
  - `io_halt` stays 0 and further requests are refused.
  - Release the consumer → `io_halt` = 1 one cycle after the third pop, `io_exitCode` = 0x2A.
- Ready gating: `ready` = 0 with `io_req_valid` = 1 → no accept and no resp, while queued bytes still drain. `ready` back to 1 → accepted that same cycle.
- Reset in DRAIN: assert `reset` with 2 bytes queued → next cycle `io_out_valid` = 0, `io_halt` = 0, state RUN; a subsequent char store works normally.
